// File: rtl/mul_io_pkg.sv
// Shared types and constants for the multiplier pin-side sequencer.
// Pin bit positions on uio_in/uio_out and the FSM state encoding.
package mul_io_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_B,
        CALC,
        OUT_LO,
        OUT_HI
    } state_e;

    // uio_in control bits
    localparam int unsigned UIO_STB  = 0;
    localparam int unsigned UIO_ACK  = 1;
    localparam int unsigned UIO_CLR  = 2;

    // uio_out status bits
    localparam int unsigned UIO_DONE = 4;
    localparam int unsigned UIO_BSEL = 5;
    localparam int unsigned UIO_BUSY = 6;
    localparam int unsigned UIO_PAR  = 7;

    localparam logic [7:0] UIO_OE_VAL = 8'hF0;

endpackage

// File: rtl/mul_io_edge_sync.sv
// Two-flop synchronizer with rising-edge detector for one host control pin.
// level is the synchronized pin; pulse_c is high for one clock on its rise.
module mul_io_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic pulse_c
);

    logic [2:0] sync_q;

    // sync_q[1:0] form the synchronizer, sync_q[2] remembers the previous level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], d};
        end
    end

    assign level   = sync_q[1];
    assign pulse_c = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/mul_io_sequencer.sv
// Host-side front end for the 8b approximate multiplier: byte-serial operand
// load, product readback with ack. Optional parity on uio_out[7] via MULIO_PARITY_EN.
module mul_io_sequencer
    import mul_io_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned PROD_W  = 16,
    parameter int unsigned MUL_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [DATA_W-1:0] ui_in,
    input  logic [7:0]        uio_in,
    output logic [DATA_W-1:0] uo_out,
    output logic [7:0]        uio_out,
    output logic [7:0]        uio_oe,
    output logic [DATA_W-1:0] mul_a,
    output logic [DATA_W-1:0] mul_b,
    input  logic [PROD_W-1:0] mul_p
);

    localparam int unsigned CNT_W = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;

    logic stb_p;
    logic ack_p;
    logic clr_lvl;
    logic unused_stb_lvl;
    logic unused_ack_lvl;
    logic unused_clr_pulse;
    logic unused_uio;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;
    logic [PROD_W-1:0]  p_q, p_d;
    logic [DATA_W-1:0]  ui_d1_q, ui_d2_q;
    logic [DATA_W-1:0]  uo_d;
    logic [7:0]         uio_d;

    assign unused_uio = ^uio_in[7:3];

    mul_io_edge_sync u_stb_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .d       (uio_in[UIO_STB]),
        .level   (unused_stb_lvl),
        .pulse_c (stb_p)
    );

    mul_io_edge_sync u_ack_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .d       (uio_in[UIO_ACK]),
        .level   (unused_ack_lvl),
        .pulse_c (ack_p)
    );

    mul_io_edge_sync u_clr_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .d       (uio_in[UIO_CLR]),
        .level   (clr_lvl),
        .pulse_c (unused_clr_pulse)
    );

    // Operand byte delayed to line up with the synchronized strobe pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ui_d1_q <= '0;
            ui_d2_q <= '0;
        end else begin
            ui_d1_q <= ui_in;
            ui_d2_q <= ui_d1_q;
        end
    end

    // State, operand/product and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            uo_out  <= '0;
            uio_out <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            uo_out  <= uo_d;
            uio_out <= uio_d;
        end
    end

    // Next-state and datapath; ena low holds everything, clear wins over pulses
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        if (ena) begin
            if (clr_lvl) begin
                state_d = IDLE;
                cnt_d   = '0;
                a_d     = '0;
                b_d     = '0;
                p_d     = '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (stb_p) begin
                            a_d     = ui_d2_q;
                            state_d = WAIT_B;
                        end
                    end
                    WAIT_B: begin
                        if (stb_p) begin
                            b_d     = ui_d2_q;
                            cnt_d   = CNT_W'(MUL_LAT);
                            state_d = CALC;
                        end
                    end
                    CALC: begin
                        if (cnt_q == '0) begin
                            p_d     = mul_p;
                            state_d = OUT_LO;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                    OUT_LO: begin
                        if (ack_p) begin
                            state_d = OUT_HI;
                        end
                    end
                    OUT_HI: begin
                        if (ack_p) begin
                            state_d = IDLE;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    // Pin outputs follow the state being entered so they land with it
    always_comb begin
        uo_d  = '0;
        uio_d = '0;
        case (state_d)
            OUT_LO:  uo_d = p_d[DATA_W-1:0];
            OUT_HI:  uo_d = p_d[PROD_W-1:DATA_W];
            default: uo_d = '0;
        endcase
        uio_d[UIO_DONE] = (state_d == OUT_LO) || (state_d == OUT_HI);
        uio_d[UIO_BSEL] = (state_d == OUT_HI);
        uio_d[UIO_BUSY] = (state_d == WAIT_B) || (state_d == CALC);
`ifdef MULIO_PARITY_EN
        uio_d[UIO_PAR]  = ^uo_d;
`else
        uio_d[UIO_PAR]  = 1'b0;
`endif
    end

    assign uio_oe = UIO_OE_VAL;
    assign mul_a  = a_q;
    assign mul_b  = b_q;

endmodule
